div_error_monitor: RTL and testbench

//  Downstream error monitor for the 16/8 approximate array divider. Each cycle it can take one

---
 rtl/div_error_monitor.sv | 142 ++++++++++++++
 tb/tb_div_error_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_error_monitor.sv
// Error statistics monitor for the approximate divider: accumulates |dq| sum/max and q/r mismatch count over a window.
// Latency: sample visible in stats 2 cycles after accept, done 3 cycles after final accept; in_ready only while the window is open.
module div_error_monitor #(
    parameter int DW        = 8,
    parameter int CNT_W     = 24,
    parameter int SUM_W     = 32,
    parameter int N_SAMPLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    q_apx,
    input  logic [DW-1:0]    r_apx,
    input  logic [DW-1:0]    q_ex,
    input  logic [DW-1:0]    r_ex,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [SUM_W-1:0] sum_abs_q,
    output logic [DW-1:0]    max_abs_q,
    output logic             sum_sat
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic               done_q, done_d;
    logic               s1_vld_q, s1_vld_d;
    logic [DW-1:0]      s1_diff_q, s1_diff_d;
    logic               s1_mis_q, s1_mis_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   mis_q, mis_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [DW-1:0]      max_q, max_d;
    logic               sat_q, sat_d;
    logic               accept;
    logic [SUM_W:0]     sum_ext;

    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        mis_d     = mis_q;
        sum_d     = sum_q;
        max_d     = max_q;
        sat_d     = sat_q;

        // A sample coinciding with start belongs to no window and is dropped.
        accept    = in_valid && (state_q == RUN) && !start;
        s1_vld_d  = accept;
        s1_diff_d = (q_apx >= q_ex) ? (q_apx - q_ex) : (q_ex - q_apx);
        s1_mis_d  = (q_apx != q_ex) || (r_apx != r_ex);

        case (state_q)
            RUN: begin
                if (accept) begin
                    issued_d = issued_q + 1'b1;
                    if (issued_d == N_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!s1_vld_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase

        sum_ext = {1'b0, sum_q} + {{(SUM_W + 1 - DW){1'b0}}, s1_diff_q};

        if (start) begin
            state_d  = RUN;
            issued_d = '0;
            done_d   = 1'b0;
            cnt_d    = '0;
            mis_d    = '0;
            sum_d    = '0;
            max_d    = '0;
            sat_d    = 1'b0;
        end else if (s1_vld_q) begin
            cnt_d = cnt_q + 1'b1;
            mis_d = mis_q + {{(CNT_W - 1){1'b0}}, s1_mis_q};
            if (sum_ext[SUM_W]) begin
                sum_d = '1;
                sat_d = 1'b1;
            end else begin
                sum_d = sum_ext[SUM_W-1:0];
            end
            if (s1_diff_q > max_q) begin
                max_d = s1_diff_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            issued_q  <= '0;
            done_q    <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_diff_q <= '0;
            s1_mis_q  <= 1'b0;
            cnt_q     <= '0;
            mis_q     <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            issued_q  <= issued_d;
            done_q    <= done_d;
            s1_vld_q  <= s1_vld_d;
            s1_diff_q <= s1_diff_d;
            s1_mis_q  <= s1_mis_d;
            cnt_q     <= cnt_d;
            mis_q     <= mis_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            sat_q     <= sat_d;
        end
    end

    assign in_ready     = (state_q == RUN);
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = done_q;
    assign sample_cnt   = cnt_q;
    assign mismatch_cnt = mis_q;
    assign sum_abs_q    = sum_q;
    assign max_abs_q    = max_q;
    assign sum_sat      = sat_q;

endmodule

// File: tb/tb_div_error_monitor.sv
// Bench for div_error_monitor: a window-level reference model predicts handshake, done timing and stats every cycle.
module tb_div_error_monitor;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  q_apx, r_apx, q_ex, r_ex;

    logic        in_ready, busy, done, sum_sat;
    logic [23:0] sample_cnt, mismatch_cnt;
    logic [31:0] sum_abs_q;
    logic [7:0]  max_abs_q;

    logic        s_in_ready, s_busy, s_done, s_sum_sat;
    logic [23:0] s_sample_cnt, s_mismatch_cnt;
    logic [7:0]  s_sum_abs_q;
    logic [7:0]  s_max_abs_q;

    always #5 clk = ~clk;

    div_error_monitor #(.DW(8), .CNT_W(24), .SUM_W(32), .N_SAMPLES(NS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .q_apx(q_apx), .r_apx(r_apx), .q_ex(q_ex), .r_ex(r_ex),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt),
        .sum_abs_q(sum_abs_q), .max_abs_q(max_abs_q), .sum_sat(sum_sat)
    );

    div_error_monitor #(.DW(8), .CNT_W(24), .SUM_W(8), .N_SAMPLES(5)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .q_apx(q_apx), .r_apx(r_apx), .q_ex(q_ex), .r_ex(r_ex),
        .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .mismatch_cnt(s_mismatch_cnt),
        .sum_abs_q(s_sum_abs_q), .max_abs_q(s_max_abs_q), .sum_sat(s_sum_sat)
    );

    typedef struct {
        int cyc;
        int diff;
        bit mis;
    } sample_t;

    int      checks   = 0;
    int      failures = 0;
    int      cyc      = 0;
    int      done_cyc = -1;
    int      issued   = 0;
    int      done_seen = 0;
    bit      run_m    = 0;
    sample_t win[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run_m    = 0;
        issued   = 0;
        done_cyc = -1;
        win.delete();
    endtask

    // One clock cycle: apply inputs, compare all outputs mid-cycle, then advance the model.
    task automatic step(input logic st, input logic vld, input logic [7:0] qa, input logic [7:0] ra,
                        input logic [7:0] qe, input logic [7:0] re);
        bit     exp_ready, exp_done, exp_busy, acc;
        longint e_cnt, e_mis, e_sum, e_max;
        sample_t s;
        start = st; in_valid = vld; q_apx = qa; r_apx = ra; q_ex = qe; r_ex = re;
        @(negedge clk);
        exp_ready = run_m && (issued < NS);
        exp_done  = (cyc == done_cyc);
        exp_busy  = run_m || (cyc < done_cyc);
        e_cnt = 0; e_mis = 0; e_sum = 0; e_max = 0;
        foreach (win[i]) begin
            if (win[i].cyc <= cyc - 2) begin
                e_cnt++;
                e_mis += win[i].mis;
                e_sum += win[i].diff;
                if (win[i].diff > e_max) e_max = win[i].diff;
            end
        end
        chk("in_ready", in_ready, exp_ready);
        chk("done", done, exp_done);
        chk("busy", busy, exp_busy);
        chk("sample_cnt", sample_cnt, e_cnt);
        chk("mismatch_cnt", mismatch_cnt, e_mis);
        chk("sum_abs_q", sum_abs_q, (e_sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e_sum);
        chk("max_abs_q", max_abs_q, e_max);
        chk("sum_sat", sum_sat, e_sum > 64'hFFFF_FFFF);
        if (done === 1'b1) done_seen++;
        acc = vld && exp_ready && !st;
        if (st) begin
            model_reset();
            run_m = 1;
        end else if (acc) begin
            s.cyc  = cyc;
            s.diff = (qa >= qe) ? int'(qa) - int'(qe) : int'(qe) - int'(qa);
            s.mis  = (qa != qe) || (ra != re);
            win.push_back(s);
            issued++;
            if (issued == NS) begin
                run_m    = 0;
                done_cyc = cyc + 3;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 0; in_valid = 0; q_apx = 0; r_apx = 0; q_ex = 0; r_ex = 0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state of both instances
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_sum", sum_abs_q, 0);
        chk("rst_sat_in_ready", s_in_ready, 0);
        chk("rst_sat_sum", s_sum_abs_q, 0);
        rst_n = 1'b1;
        idle(5);

        // Exact samples: no error accumulated, single done pulse 3 cycles after last accept
        done_seen = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 5, 2, 5, 2);
        idle(5);
        chk("t2_sample_cnt", sample_cnt, 4);
        chk("t2_mismatch", mismatch_cnt, 0);
        chk("t2_sum", sum_abs_q, 0);
        chk("t2_max", max_abs_q, 0);
        chk("t2_done_pulses", done_seen, 1);

        // Mixed errors
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 10, 1, 7, 1);
        step(0, 1, 3, 0, 9, 0);
        step(0, 1, 4, 2, 4, 5);
        step(0, 1, 4, 2, 4, 2);
        idle(5);
        chk("t3_sum", sum_abs_q, 9);
        chk("t3_max", max_abs_q, 6);
        chk("t3_mismatch", mismatch_cnt, 3);
        chk("t3_sample_cnt", sample_cnt, 4);

        // Backpressure: valid held high past the window
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 7, 0, 6, 0);
        idle(3);
        chk("t5_sample_cnt", sample_cnt, 4);
        chk("t5_sum", sum_abs_q, 4);

        // Abort with a sample in the start cycle
        done_seen = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 9, 0, 5, 0);
        step(1, 1, 9, 0, 5, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 6, 0, 5, 0);
        idle(5);
        chk("t6_sum", sum_abs_q, 4);
        chk("t6_sample_cnt", sample_cnt, 4);
        chk("t6_done_pulses", done_seen, 1);

        // Saturation on the narrow-accumulator instance
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 255, 0, 0, 0);
        idle(5);
        chk("t4_sum", s_sum_abs_q, 255);
        chk("t4_sat", s_sum_sat, 1);
        chk("t4_max", s_max_abs_q, 255);
        chk("t4_sample_cnt", s_sample_cnt, 5);
        chk("t4_mismatch", s_mismatch_cnt, 5);
        chk("t4_done", s_done, 0);

        // Restart in the same cycle as done
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8, 0, 2, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 0);
        idle(2);
        chk("restart_sum", sum_abs_q, 0);
        chk("restart_ready", in_ready, 1);

        // Asynchronous reset mid-window
        step(0, 1, 3, 0, 1, 0);
        step(0, 1, 3, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_sample_cnt", sample_cnt, 0);
        chk("arst_sum", sum_abs_q, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(3);

        // Randomized windows with occasional aborts
        for (int w = 0; w < 40; w++) begin
            step(1, 0, 0, 0, 0, 0);
            for (int k = 0; k < 14; k++) begin
                logic [7:0] qa, qe, ra, re;
                qa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
                qe = 8'($urandom_range(0, 15));
                ra = 8'($urandom_range(0, 3));
                re = 8'($urandom_range(0, 3));
                step(($urandom_range(0, 29) == 0), ($urandom_range(0, 1) == 1), qa, ra, qe, re);
            end
            idle($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
